// File: rtl/accel_stim_gen.sv
// accel_stim_gen: request-driven data/weight stimulus source with bounded, repeatable runs.
// Defining STIM_GEN_LFSR_EN turns mode 2 into a per-stream 16-bit Galois LFSR pattern.
module accel_stim_gen #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int DATA_LEN    = 16,
  parameter int WEIGHT_LEN  = 9,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_start,
  input  logic [1:0]                                  i_mode,
  input  logic                                        i_data_req,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0]            o_data,
  output logic                                        o_data_val,
  input  logic                                        i_weight_req,
  output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] o_weight,
  output logic                                        o_weight_val,
  output logic [CNT_WIDTH-1:0]                        o_data_cnt,
  output logic [CNT_WIDTH-1:0]                        o_weight_cnt,
  output logic                                        o_done
);
  localparam int G  = BIT_WIDTH * NUM_CHANNEL;
  localparam int WW = G * NUM_KERNEL;
  localparam logic [CNT_WIDTH-1:0] DLEN = CNT_WIDTH'(DATA_LEN);
  localparam logic [CNT_WIDTH-1:0] WLEN = CNT_WIDTH'(WEIGHT_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0] mode;
  logic       d_acc, w_acc, hold;

  logic [NUM_CHANNEL-1:0][BIT_WIDTH-1:0] dgen, dseed, dinc, dword;
  logic [NUM_KERNEL-1:0][G-1:0]          wgen, wseed, winc, wword;

  for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_dlane
    assign dseed[c] = BIT_WIDTH'(c * 16);
    assign dinc[c]  = dgen[c] + BIT_WIDTH'(1);
  end

  // Each group increments as one wide integer; no carry crosses into the next group.
  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_wgrp
    assign wseed[k] = G'(k);
    assign winc[k]  = wgen[k] + G'(1);
  end

  // A request coinciding with i_start is dropped so the new run begins cleanly.
  assign d_acc = (state == RUN) && !i_start && i_data_req   && (o_data_cnt   < DLEN);
  assign w_acc = (state == RUN) && !i_start && i_weight_req && (o_weight_cnt < WLEN);
  assign hold  = (mode == 2'd1);
  assign o_done = (state == DONE);

`ifdef STIM_GEN_LFSR_EN
  logic [15:0]                           dlfsr, wlfsr;
  logic [NUM_CHANNEL-1:0][BIT_WIDTH-1:0] dlw;
  logic [WW-1:0]                         wlw;
  logic                                  lfsr_mode;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign lfsr_mode = (mode == 2'd2);

  for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_dlfsr
    assign dlw[c] = dlfsr[BIT_WIDTH-1:0] + BIT_WIDTH'(c);
  end

  for (genvar j = 0; j < NUM_KERNEL * NUM_CHANNEL; j++) begin : g_wlfsr
    assign wlw[j*BIT_WIDTH +: BIT_WIDTH] = wlfsr[BIT_WIDTH-1:0] + BIT_WIDTH'(j);
  end

  assign dword = lfsr_mode ? dlw : dgen;
  assign wword = lfsr_mode ? wlw : wgen;

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      dlfsr <= 16'hACE1;
      wlfsr <= 16'h1D0F;
    end else begin
      if (d_acc) dlfsr <= lfsr_step(dlfsr);
      if (w_acc) wlfsr <= lfsr_step(wlfsr);
    end
  end
`else
  assign dword = dgen;
  assign wword = wgen;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (!i_start && o_data_cnt == DLEN && o_weight_cnt == WLEN) state_nxt = DONE;
      DONE:    if (i_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode         <= 2'd0;
      dgen         <= dseed;
      wgen         <= wseed;
      o_data       <= '0;
      o_weight     <= '0;
      o_data_val   <= 1'b0;
      o_weight_val <= 1'b0;
      o_data_cnt   <= '0;
      o_weight_cnt <= '0;
    end else begin
      state        <= state_nxt;
      o_data_val   <= d_acc;
      o_weight_val <= w_acc;
      if (i_start) begin
        mode         <= i_mode;
        dgen         <= dseed;
        wgen         <= wseed;
        o_data_cnt   <= '0;
        o_weight_cnt <= '0;
      end else begin
        if (d_acc) begin
          o_data     <= dword;
          o_data_cnt <= o_data_cnt + CNT_WIDTH'(1);
          if (!hold) dgen <= dinc;
        end
        if (w_acc) begin
          o_weight     <= wword;
          o_weight_cnt <= o_weight_cnt + CNT_WIDTH'(1);
          if (!hold) wgen <= winc;
        end
      end
    end
  end
endmodule
